// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: truth-table read-back for a 4-input combinational circuit.
// Drives the 16 input rows in order. Each row is held for SETTLE_CYCLES and
// then the synchronized DUT output is sampled. The measured 16-bit code is
// compared against an expected code that is captured at start.
// Optional macro TT_GLITCH_CHECK_EN adds the unstable[15:0] output, which
// flags rows whose synchronized output moved late in the settle window.
module tt_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 8,  // 1..255, >= SYNC_STAGES
  parameter int unsigned SYNC_STAGES   = 2   // 2..3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  output logic        dut_in1,
  output logic        dut_in2,
  output logic        dut_in3,
  output logic        dut_in4,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt_code,
  output logic        pass,
  output logic [15:0] mismatch
`ifdef TT_GLITCH_CHECK_EN
  ,output logic [15:0] unstable
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
`ifdef TT_GLITCH_CHECK_EN
  localparam logic [7:0] SYNC_CNT    = 8'(SYNC_STAGES);
`endif

  state_t                 state, state_nxt;
  logic [3:0]             row;
  logic [7:0]             settle_cnt;
  logic [3:0]             dut_in_q;
  logic [15:0]            exp_q;
  logic [15:0]            tt_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   accept;
`ifdef TT_GLITCH_CHECK_EN
  logic                   ref_q;
`endif

  // Abort has priority over start, even in IDLE.
  assign accept   = (state == S_IDLE) && start && !abort;
  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchronize the asynchronous DUT output into clk.
  // NOTE: all sequential state uses non-blocking assignments, so every flop
  // samples the pre-edge value of its neighbours, which makes the shift chain work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dut_out};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Abort from any non-IDLE state returns to IDLE.
  // NOTE: the default assignment at the top of the block keeps this
  // combinational block free of inferred latches.
  always_comb begin
    state_nxt = state;
    if (state == S_IDLE) begin
      if (accept) state_nxt = S_APPLY;
    end else if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_APPLY:  state_nxt = S_SETTLE;
        S_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
        S_SAMPLE: state_nxt = (row == 4'd15) ? S_DONE : S_APPLY;
        S_DONE:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_APPLY, S_SETTLE, S_SAMPLE: busy = 1'b1;
      S_DONE:                      done = 1'b1;
      default: ;
    endcase
  end

  assign {dut_in1, dut_in2, dut_in3, dut_in4} = dut_in_q;

  // tt_code with the current row's bit merged in. For a 4-bit row the bit
  // index 15-row equals ~row.
  always_comb begin
    tt_next       = tt_code;
    tt_next[~row] = sync_out;
  end

  // Datapath: row sequencing, DUT drive, result capture and verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row        <= '0;
      settle_cnt <= '0;
      dut_in_q   <= '0;
      exp_q      <= '0;
      tt_code    <= '0;
      pass       <= 1'b0;
      mismatch   <= '0;
`ifdef TT_GLITCH_CHECK_EN
      ref_q      <= 1'b0;
      unstable   <= '0;
`endif
    end else if (state == S_IDLE) begin
      if (accept) begin
        exp_q    <= expected;
        tt_code  <= '0;
        mismatch <= '0;
        pass     <= 1'b0;
        row      <= '0;
`ifdef TT_GLITCH_CHECK_EN
        unstable <= '0;
`endif
      end
    end else if (abort) begin
      // Partial tt_code is kept for debug; the verdict is withdrawn.
      dut_in_q <= '0;
      pass     <= 1'b0;
    end else begin
      case (state)
        S_APPLY: begin
          dut_in_q   <= row;
          settle_cnt <= '0;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt + 8'd1;
`ifdef TT_GLITCH_CHECK_EN
          // The first fully synchronized sample of the row is the reference.
          // Any later difference within the settle window marks the row unstable.
          if (settle_cnt == SYNC_CNT) begin
            ref_q <= sync_out;
          end else if (settle_cnt > SYNC_CNT && sync_out != ref_q) begin
            unstable[~row] <= 1'b1;
          end
`endif
        end
        S_SAMPLE: begin
          tt_code <= tt_next;
          if (row == 4'd15) begin
            mismatch <= tt_next ^ exp_q;
`ifdef TT_GLITCH_CHECK_EN
            pass     <= (tt_next == exp_q) && (unstable == '0);
`else
            pass     <= (tt_next == exp_q);
`endif
          end else begin
            row <= row + 4'd1;
          end
        end
        S_DONE: begin
          dut_in_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
